// File: rtl/mdio_master_if.sv
// Command/response bus between a register requester and the MDIO management station.
// The requester uses the master modport and mdio_master uses the slave modport.
interface mdio_master_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [4:0]  cmd_phy_addr;
   logic [4:0]  cmd_reg_addr;
   logic [15:0] cmd_wdata;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output cmd_valid, cmd_write, cmd_phy_addr, cmd_reg_addr, cmd_wdata,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  cmd_valid, cmd_write, cmd_phy_addr, cmd_reg_addr, cmd_wdata,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/mdio_master.sv
// Clause-22 MDIO management station: turns one register command into an MDC/MDIO frame.
// It returns read data and a no-responder flag, with a one-cycle rsp_valid per frame.
module mdio_master #(
   parameter int MDC_HALF     = 40,
   parameter int PREAMBLE_LEN = 32
) (
   input  logic         clk_200m,
   input  logic         rstn_200m,
   mdio_master_if.slave cmd_bus,
   output logic         mdc,
   output logic         mdio_out,
   output logic         mdio_oen,
   input  logic         mdio_in
);

   localparam int DIV_W = $clog2(2 * MDC_HALF);
   localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(2 * MDC_HALF - 1);
   localparam logic [DIV_W-1:0] DIV_RISE    = DIV_W'(MDC_HALF);
   localparam logic [DIV_W-1:0] DIV_RISE_M1 = DIV_W'(MDC_HALF - 1);
   localparam logic [5:0]       PRE_LAST    = (PREAMBLE_LEN == 0) ? 6'd0 : 6'(PREAMBLE_LEN - 1);

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_PRE  = 3'd1;
   localparam logic [2:0] ST_HDR  = 3'd2;
   localparam logic [2:0] ST_TA   = 3'd3;
   localparam logic [2:0] ST_DATA = 3'd4;
   localparam logic [2:0] ST_DONE = 3'd5;

   logic [2:0]       state;
   logic [DIV_W-1:0] div_cnt;
   logic [5:0]       bit_cnt;
   logic [31:0]      tx_sr;     // tx_sr[31] is the bit on the wire during HDR/TA/DATA
   logic [15:0]      rx_sr;
   logic             is_read;
   logic             ta_err;

   logic [2:0]  nxt_state;
   logic [5:0]  nxt_bit_cnt;
   logic        nxt_drive;
   logic        nxt_release;
   logic        shift_en;
   logic [31:0] cmd_frame;

   assign cmd_bus.cmd_ready = (state == ST_IDLE);

   // Reads load TA and data as ones so the shifter matches the released (pulled-up) line.
   assign cmd_frame = {2'b01,
                       cmd_bus.cmd_write ? 2'b01 : 2'b10,
                       cmd_bus.cmd_phy_addr,
                       cmd_bus.cmd_reg_addr,
                       cmd_bus.cmd_write ? 2'b10 : 2'b11,
                       cmd_bus.cmd_write ? cmd_bus.cmd_wdata : 16'hFFFF};

   // Decide what the next bit is, evaluated only when the current bit ends.
   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      nxt_state   = state;
      nxt_bit_cnt = bit_cnt + 6'd1;
      nxt_drive   = tx_sr[30];
      shift_en    = 1'b1;
      case (state)
         ST_PRE: begin
            shift_en  = 1'b0;
            nxt_drive = 1'b1;
            if (bit_cnt == PRE_LAST) begin
               nxt_state   = ST_HDR;
               nxt_bit_cnt = 6'd0;
               nxt_drive   = tx_sr[31];
            end
         end
         ST_HDR: begin
            if (bit_cnt == 6'd13) begin
               nxt_state   = ST_TA;
               nxt_bit_cnt = 6'd0;
            end
         end
         ST_TA: begin
            if (bit_cnt == 6'd1) begin
               nxt_state   = ST_DATA;
               nxt_bit_cnt = 6'd0;
            end
         end
         ST_DATA: begin
            if (bit_cnt == 6'd15) begin
               nxt_state   = ST_DONE;
               nxt_bit_cnt = 6'd0;
            end
         end
         default: begin
            shift_en  = 1'b0;
            nxt_drive = 1'b1;
         end
      endcase
      nxt_release = (nxt_state == ST_DONE) ||
                    (is_read && ((nxt_state == ST_TA) || (nxt_state == ST_DATA)));
   end

   always_ff @(posedge clk_200m or negedge rstn_200m) begin
      if (!rstn_200m) begin
         state             <= ST_IDLE;
         div_cnt           <= '0;
         bit_cnt           <= 6'd0;
         tx_sr             <= 32'd0;
         rx_sr             <= 16'd0;
         is_read           <= 1'b0;
         ta_err            <= 1'b0;
         mdc               <= 1'b0;
         mdio_out          <= 1'b1;
         mdio_oen          <= 1'b1;
         cmd_bus.rsp_valid <= 1'b0;
         cmd_bus.rsp_rdata <= 16'd0;
         cmd_bus.rsp_err   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register sees pre-edge values.
         cmd_bus.rsp_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               mdc <= 1'b0;
               if (cmd_bus.cmd_valid) begin
                  tx_sr    <= cmd_frame;
                  is_read  <= !cmd_bus.cmd_write;
                  ta_err   <= 1'b0;
                  div_cnt  <= '0;
                  bit_cnt  <= 6'd0;
                  mdio_oen <= 1'b0;
                  if (PREAMBLE_LEN == 0) begin
                     state    <= ST_HDR;
                     mdio_out <= cmd_frame[31];
                  end else begin
                     state    <= ST_PRE;
                     mdio_out <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               // Sample on the first cycle of the MDC high phase.
               if (is_read && (div_cnt == DIV_RISE)) begin
                  if ((state == ST_TA) && (bit_cnt == 6'd1))
                     ta_err <= mdio_in;
                  if (state == ST_DATA)
                     rx_sr <= {rx_sr[14:0], mdio_in};
               end
               if (div_cnt == DIV_LAST) begin
                  div_cnt  <= '0;
                  mdc      <= 1'b0;
                  state    <= nxt_state;
                  bit_cnt  <= nxt_bit_cnt;
                  mdio_oen <= nxt_release;
                  mdio_out <= nxt_release | nxt_drive;
                  if (shift_en)
                     tx_sr <= {tx_sr[30:0], 1'b0};
                  if (nxt_state == ST_DONE) begin
                     cmd_bus.rsp_valid <= 1'b1;
                     if (is_read) begin
                        cmd_bus.rsp_rdata <= rx_sr;
                        cmd_bus.rsp_err   <= ta_err;
                     end else begin
                        cmd_bus.rsp_err   <= 1'b0;
                     end
                  end
               end else begin
                  div_cnt <= div_cnt + 1'b1;
                  if (div_cnt == DIV_RISE_M1)
                     mdc <= 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mdio_master.sv
// Directed bench for mdio_master: one instance with H=2/P=32 and one with H=3/P=0.
// It includes a bench-side PHY that answers reads off MDC falling edges.
module tb_mdio_master;

   logic clk_200m = 1'b0;
   logic rstn_200m;
   logic mdio_in;
   logic mdc_a, out_a, oen_a;
   logic mdc_b, out_b, oen_b;

   mdio_master_if bus_a();
   mdio_master_if bus_b();

   mdio_master #(.MDC_HALF(2), .PREAMBLE_LEN(32)) u_dut_a (
      .clk_200m (clk_200m),
      .rstn_200m(rstn_200m),
      .cmd_bus  (bus_a.slave),
      .mdc      (mdc_a),
      .mdio_out (out_a),
      .mdio_oen (oen_a),
      .mdio_in  (mdio_in)
   );

   mdio_master #(.MDC_HALF(3), .PREAMBLE_LEN(0)) u_dut_b (
      .clk_200m (clk_200m),
      .rstn_200m(rstn_200m),
      .cmd_bus  (bus_b.slave),
      .mdc      (mdc_b),
      .mdio_out (out_b),
      .mdio_oen (oen_b),
      .mdio_in  (mdio_in)
   );

   always #5 clk_200m = ~clk_200m;

   int n_checks = 0;
   int n_errors = 0;
   bit use_b = 1'b0;

   wire        obs_mdc       = use_b ? mdc_b : mdc_a;
   wire        obs_out       = use_b ? out_b : out_a;
   wire        obs_oen       = use_b ? oen_b : oen_a;
   wire        obs_ready     = use_b ? bus_b.cmd_ready : bus_a.cmd_ready;
   wire        obs_rsp_valid = use_b ? bus_b.rsp_valid : bus_a.rsp_valid;
   wire [15:0] obs_rdata     = use_b ? bus_b.rsp_rdata : bus_a.rsp_rdata;
   wire        obs_err       = use_b ? bus_b.rsp_err   : bus_a.rsp_err;

   logic [63:0] vo, ve;
   int          rc;
   logic [15:0] rd;
   logic        er;
   int          bad;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic start_cmd(input bit wr, input logic [4:0] phy, input logic [4:0] regad,
                            input logic [15:0] wdata, input bit hold, input string tag);
      @(negedge clk_200m);
      bus_a.cmd_write = wr;  bus_a.cmd_phy_addr = phy;  bus_a.cmd_reg_addr = regad;  bus_a.cmd_wdata = wdata;
      bus_b.cmd_write = wr;  bus_b.cmd_phy_addr = phy;  bus_b.cmd_reg_addr = regad;  bus_b.cmd_wdata = wdata;
      if (use_b) bus_b.cmd_valid = 1'b1;
      else       bus_a.cmd_valid = 1'b1;
      check({tag, "_ready0"}, obs_ready, 1);
      @(posedge clk_200m);
      #1;
      if (!hold) begin
         bus_a.cmd_valid = 1'b0;
         bus_b.cmd_valid = 1'b0;
      end
   endtask

   // Runs one full frame; v_out/v_oen hold the line value seen at each MDC rising edge, MSB = first bit.
   task automatic run_frame(input bit wr, input logic [4:0] phy, input logic [4:0] regad,
                            input logic [15:0] wdata, input bit responder, input logic [15:0] sdata,
                            input bit hold, input string tag,
                            output logic [63:0] v_out, output logic [63:0] v_oen,
                            output int rsp_cyc, output logic [15:0] rdata, output logic err);
      int h, p, n, d, ph, k, j;
      int n_rsp, busy_ready, mdc_bad, chg_bad;
      logic [2:0] done_pins;
      logic prev_out, prev_oen, exp_mdc;
      h = use_b ? 3 : 2;
      p = use_b ? 0 : 32;
      n = p + 32;
      d = 1 + 2 * n * h;
      n_rsp = 0; busy_ready = 0; mdc_bad = 0; chg_bad = 0;
      done_pins = 3'b000; prev_out = 1'b1; prev_oen = 1'b1;
      v_out = '0; v_oen = '0; rsp_cyc = 0; rdata = '0; err = 1'b0;
      start_cmd(wr, phy, regad, wdata, hold, tag);
      for (int c = 1; c <= d; c++) begin
         @(negedge clk_200m);
         ph = (c - 1) % (2 * h);
         k  = (c - 1) / (2 * h);
         j  = k - p;
         if (c < d && ph == 0) begin
            mdio_in = 1'b1;
            if (responder && !wr) begin
               if (j == 15)      mdio_in = 1'b0;
               else if (j >= 16) mdio_in = sdata[31 - j];
            end
         end
         if (c == d) mdio_in = 1'b1;
         exp_mdc = (c < d) && (ph >= h);
         if (obs_mdc !== exp_mdc) mdc_bad++;
         if (c < d && ph == h) begin
            v_out[n - 1 - k] = obs_out;
            v_oen[n - 1 - k] = obs_oen;
         end
         if (c > 1 && c < d && ph != 0 && (obs_out !== prev_out || obs_oen !== prev_oen)) chg_bad++;
         prev_out = obs_out;
         prev_oen = obs_oen;
         if (obs_ready) busy_ready++;
         if (obs_rsp_valid === 1'b1) begin
            n_rsp++;
            if (rsp_cyc == 0) rsp_cyc = c;
            rdata = obs_rdata;
            err   = obs_err;
         end
         if (c == d) done_pins = {obs_mdc, obs_out, obs_oen};
      end
      check({tag, "_mdc_shape"}, mdc_bad, 0);
      check({tag, "_mid_bit_change"}, chg_bad, 0);
      check({tag, "_ready_busy"}, busy_ready, 0);
      check({tag, "_rsp_count"}, n_rsp, 1);
      check({tag, "_done_pins"}, done_pins, 3'b011);
   endtask

   initial begin
      rstn_200m = 1'b0;
      mdio_in   = 1'b1;
      bus_a.cmd_valid = 1'b0; bus_a.cmd_write = 1'b0; bus_a.cmd_phy_addr = '0; bus_a.cmd_reg_addr = '0; bus_a.cmd_wdata = '0;
      bus_b.cmd_valid = 1'b0; bus_b.cmd_write = 1'b0; bus_b.cmd_phy_addr = '0; bus_b.cmd_reg_addr = '0; bus_b.cmd_wdata = '0;
      repeat (3) @(negedge clk_200m);
      check("rst_pins_a", {bus_a.cmd_ready, bus_a.rsp_valid, bus_a.rsp_err, mdc_a, out_a, oen_a}, 6'b100011);
      check("rst_rdata_a", bus_a.rsp_rdata, 16'h0000);
      check("rst_pins_b", {bus_b.cmd_ready, bus_b.rsp_valid, bus_b.rsp_err, mdc_b, out_b, oen_b}, 6'b100011);
      rstn_200m = 1'b1;

      // Write, H=2, P=32.
      run_frame(1'b1, 5'h03, 5'h1F, 16'hA55A, 1'b0, 16'h0000, 1'b0, "wr1", vo, ve, rc, rd, er);
      check("wr1_bits", vo, 64'hFFFF_FFFF_51FE_A55A);
      check("wr1_oen", ve, 64'h0);
      check("wr1_rsp_cycle", rc, 257);
      check("wr1_err", er, 1'b0);

      // Read with responder.
      run_frame(1'b0, 5'h01, 5'h02, 16'h0000, 1'b1, 16'h1234, 1'b0, "rd1", vo, ve, rc, rd, er);
      check("rd1_bits", vo, 64'hFFFF_FFFF_608B_FFFF);
      check("rd1_oen", ve, 64'h0000_0000_0003_FFFF);
      check("rd1_rsp_cycle", rc, 257);
      check("rd1_rdata", rd, 16'h1234);
      check("rd1_err", er, 1'b0);

      // Read with nobody answering, then a write that must not disturb rsp_rdata.
      run_frame(1'b0, 5'h1F, 5'h00, 16'h0000, 1'b0, 16'h0000, 1'b0, "rd_nr", vo, ve, rc, rd, er);
      check("rd_nr_bits", vo, 64'hFFFF_FFFF_6F83_FFFF);
      check("rd_nr_err", er, 1'b1);
      check("rd_nr_rdata", rd, 16'hFFFF);
      run_frame(1'b1, 5'h00, 5'h00, 16'h0000, 1'b0, 16'h0000, 1'b0, "wr2", vo, ve, rc, rd, er);
      check("wr2_bits", vo, 64'hFFFF_FFFF_5002_0000);
      check("wr2_err", er, 1'b0);
      check("wr2_rdata_held", rd, 16'hFFFF);

      // No preamble, H=3; cmd_valid held through the frame.
      use_b = 1'b1;
      run_frame(1'b0, 5'h02, 5'h01, 16'h0000, 1'b1, 16'hBEEF, 1'b1, "p0_rd1", vo, ve, rc, rd, er);
      check("p0_first_bit", vo[31], 1'b0);
      check("p0_bits", vo[31:0], 32'h6107_FFFF);
      check("p0_oen", ve[31:0], 32'h0003_FFFF);
      check("p0_rsp_cycle", rc, 193);
      check("p0_rdata", rd, 16'hBEEF);
      run_frame(1'b0, 5'h1F, 5'h1F, 16'h0000, 1'b1, 16'h0F0F, 1'b0, "p0_rd2", vo, ve, rc, rd, er);
      check("p0_b2b_rsp_cycle", rc, 193);
      check("p0_rd2_rdata", rd, 16'h0F0F);
      check("p0_rd2_err", er, 1'b0);

      // Reset in the middle of data bit 5 of a write (bit 53, first MDC-high cycle 215).
      use_b = 1'b0;
      start_cmd(1'b1, 5'h07, 5'h08, 16'h1357, 1'b0, "rstw");
      repeat (214) @(posedge clk_200m);
      #2;
      check("rstw_busy", {obs_mdc, obs_oen}, 2'b10);
      rstn_200m = 1'b0;
      #1;
      check("rstw_pins", {obs_ready, obs_rsp_valid, obs_err, obs_mdc, obs_out, obs_oen}, 6'b100011);
      check("rstw_rdata", obs_rdata, 16'h0000);
      repeat (3) @(negedge clk_200m);
      rstn_200m = 1'b1;
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk_200m);
         if (!obs_ready || obs_mdc || obs_rsp_valid) bad++;
      end
      check("post_rst_idle", bad, 0);

      run_frame(1'b0, 5'h04, 5'h05, 16'h0000, 1'b1, 16'hC3A5, 1'b0, "rd_after_rst", vo, ve, rc, rd, er);
      check("rd_after_rst_cycle", rc, 257);
      check("rd_after_rst_rdata", rd, 16'hC3A5);
      check("rd_after_rst_err", er, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
